// File: rtl/accel_hazard_ctrl_pkg.sv
// vbsme_hazard_pkg: accelerator opcode, field positions and per-unit state type
package vbsme_hazard_pkg;
  localparam logic [5:0] ACCEL_OPCODE = 6'h1C;
  localparam logic [5:0] FUNCT_START = 6'h01;
  localparam logic [5:0] FUNCT_WAIT = 6'h02;
  localparam int OP_LSB = 26;
  localparam int UNIT_LSB = 21;
  localparam int FUNCT_LSB = 0;
  typedef enum logic {IDLE, BUSY} unit_state_e;
endpackage

// File: rtl/accel_hazard_ctrl_if.sv
// accel_hazard_ctrl_if: decode/completion inputs and stall/status outputs of the hazard controller
interface accel_hazard_ctrl_if #(parameter int NUM_UNITS = 2);
  logic instr_valid;
  logic [31:0] instruction;
  logic [NUM_UNITS-1:0] complete, start, busy, timeout_err;
  logic pc_stall, bad_unit_err;
  modport master(output instr_valid, instruction, complete, input pc_stall, start, busy, timeout_err, bad_unit_err);
  modport slave(input instr_valid, instruction, complete, output pc_stall, start, busy, timeout_err, bad_unit_err);
endinterface

// File: rtl/accel_hazard_ctrl_unit_tracker.sv
// accel_unit_tracker: per-unit launch pulse, busy state, completion sampling and timeout watchdog
module accel_unit_tracker
  import vbsme_hazard_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic Clk,
  input  logic Rst,
  input  logic launch,
  input  logic complete,
  output logic start,
  output logic busy,
  output logic timeout_err
);
  localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
  unit_state_e state_q, state_d;
  logic start_q, start_d, tmo_q, tmo_d, done, expire;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      tmo_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      tmo_q <= tmo_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    done = state_q == BUSY && !start_q && complete;
    expire = TIMEOUT_CYC > 0 && state_q == BUSY && cnt_q == LAST && !done;
    state_d = launch ? BUSY : (done || expire) ? IDLE : state_q;
    start_d = launch;
    tmo_d = tmo_q || expire;
    cnt_d = launch ? '0 : state_q == BUSY ? cnt_q + CW'(1) : cnt_q;
  end
  always_comb begin
    busy = state_q == BUSY;
    start = start_q;
    timeout_err = tmo_q;
  end
endmodule

// File: rtl/accel_hazard_ctrl.sv
// accel_hazard_ctrl: decodes accelerator START/WAIT, launches unit trackers and stalls the PC on hazards
module accel_hazard_ctrl
  import vbsme_hazard_pkg::*;
#(
  parameter int NUM_UNITS = 2,
  parameter bit BLOCKING = 1'b1,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic Clk,
  input logic Rst,
  accel_hazard_ctrl_if.slave bus
);
  logic [4:0] unit;
  logic is_start, is_wait, is_accel, unit_ok, pc_stall, accept, bad_q, bad_d;
  logic [31:0] busy_ext;
  logic [NUM_UNITS-1:0] launch, start_v, busy_v, tmo_v;
  always_comb begin
    unit = bus.instruction[UNIT_LSB +: 5];
    is_accel = bus.instr_valid && bus.instruction[OP_LSB +: 6] == ACCEL_OPCODE;
    is_start = is_accel && bus.instruction[FUNCT_LSB +: 6] == FUNCT_START;
    is_wait = is_accel && bus.instruction[FUNCT_LSB +: 6] == FUNCT_WAIT;
    unit_ok = 32'(unit) < NUM_UNITS;
    busy_ext = 32'(busy_v);
    pc_stall = ((is_start || is_wait) && busy_ext[unit]) || (BLOCKING && |busy_v);
    accept = is_start && unit_ok && !pc_stall;
    bad_d = bad_q || ((is_start || is_wait) && !unit_ok);
  end
  always_ff @(posedge Clk) bad_q <= Rst ? 1'b0 : bad_d;
  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    assign launch[i] = accept && unit == 5'(i);
    accel_unit_tracker #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_trk (
      .Clk(Clk),
      .Rst(Rst),
      .launch(launch[i]),
      .complete(bus.complete[i]),
      .start(start_v[i]),
      .busy(busy_v[i]),
      .timeout_err(tmo_v[i])
    );
  end
  assign bus.pc_stall = pc_stall;
  assign bus.start = start_v;
  assign bus.busy = busy_v;
  assign bus.timeout_err = tmo_v;
  assign bus.bad_unit_err = bad_q;
endmodule
